// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the instruction sequencer: state encodings,
// opcode constants and an opcode classifier used by the decoder and the bench.
package pc_sequencer_pkg;

  localparam int PC_W = 10;
  localparam int IW   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_BZ  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    CL_JUMP   = 2'd0,
    CL_BRANCH = 2'd1,
    CL_HALT   = 2'd2,
    CL_EXEC   = 2'd3
  } op_class_t;

  function automatic op_class_t classify(input logic [IW-1:0] instr);
    op_class_t cls;
    case (instr[15:12])
      OP_JMP:  cls = CL_JUMP;
      OP_BZ:   cls = CL_BRANCH;
      OP_HLT:  cls = CL_HALT;
      default: cls = CL_EXEC;
    endcase
    return cls;
  endfunction

  // A conditional branch only redirects the PC when the zero flag is set.
  function automatic logic redirects(input op_class_t cls, input logic zero);
    return (cls == CL_JUMP) || ((cls == CL_BRANCH) && zero);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer and its environment: program counter control,
// instruction memory handshake and execute-unit handshake.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic              start;
  logic [PC_W-1:0]   PC;
  logic              pc_overflow;
  logic              mem_ack;
  logic [IW-1:0]     mem_data;
  logic              zero;
  logic              ex_done;
  logic              fetch;
  logic              pc_write;
  logic [PC_W-1:0]   addr;
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic [IW-1:0]     ir;
  logic              ex_start;
  logic              halted;

  modport slave (
    input  start, PC, pc_overflow, mem_ack, mem_data, zero, ex_done,
    output fetch, pc_write, addr, mem_req, mem_addr, ir, ex_start, halted
  );

  modport master (
    output start, PC, pc_overflow, mem_ack, mem_data, zero, ex_done,
    input  fetch, pc_write, addr, mem_req, mem_addr, ir, ex_start, halted
  );

endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches from instruction memory, decodes the opcode
// and steers an external program counter and execute unit.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic             mem_req_q;
  logic             halted_q;
  op_class_t        cls_s;

  logic             fetch_s;
  logic             pc_write_s;
  logic [PC_W-1:0]  addr_s;
  logic             ex_start_s;

  assign cls_s = classify(ir_q);

  // Next-state and instruction-register load logic.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // A wrapped PC must never fetch again, even with data on the bus.
        if (bus.pc_overflow) begin
          state_d = ST_HALT;
        end else if (bus.mem_ack) begin
          state_d = ST_DECODE;
          ir_d    = bus.mem_data;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CL_JUMP:   state_d = ST_FETCH;
          CL_BRANCH: state_d = ST_FETCH;
          CL_HALT:   state_d = ST_HALT;
          default:   state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (bus.ex_done) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, instruction register and state-derived status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= 16'h0000;
      mem_req_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      mem_req_q <= (state_d == ST_FETCH);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  // PC and execute strobes decoded from state, instruction and flags.
  always_comb begin
    fetch_s    = 1'b0;
    pc_write_s = 1'b0;
    addr_s     = 10'd0;
    ex_start_s = 1'b0;
    case (state_q)
      ST_DECODE: begin
        if (redirects(cls_s, bus.zero)) begin
          pc_write_s = 1'b1;
          addr_s     = ir_q[9:0];
        end else if (cls_s == CL_BRANCH) begin
          fetch_s = 1'b1;
        end else if (cls_s == CL_EXEC) begin
          ex_start_s = 1'b1;
        end else begin
          fetch_s = 1'b0;
        end
      end
      ST_EXEC: begin
        if (bus.ex_done) begin
          fetch_s = 1'b1;
        end else begin
          fetch_s = 1'b0;
        end
      end
      default: begin
        fetch_s = 1'b0;
      end
    endcase
  end

  assign bus.fetch    = fetch_s;
  assign bus.pc_write = pc_write_s;
  assign bus.addr     = addr_s;
  assign bus.ex_start = ex_start_s;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_req_q ? bus.PC : 10'd0;
  assign bus.ir       = ir_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  pc_sequencer_if bus();

  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: which phase of instruction handling we are in.
  bit          m_wait, m_dec, m_exec, m_halt;
  logic [15:0] m_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model advance on each rising edge.
  always @(posedge clk) begin
    logic [3:0] op;
    op = m_ir[15:12];
    if (rst) begin
      m_wait <= 1'b0; m_dec <= 1'b0; m_exec <= 1'b0; m_halt <= 1'b0; m_ir <= 16'h0000;
    end else if (m_halt) begin
      m_halt <= 1'b1;
    end else if (m_wait) begin
      if (bus.pc_overflow) begin
        m_wait <= 1'b0; m_halt <= 1'b1;
      end else if (bus.mem_ack) begin
        m_wait <= 1'b0; m_dec <= 1'b1; m_ir <= bus.mem_data;
      end
    end else if (m_dec) begin
      m_dec <= 1'b0;
      if (op == 4'hE || op == 4'hD) m_wait <= 1'b1;
      else if (op == 4'hF) m_halt <= 1'b1;
      else m_exec <= 1'b1;
    end else if (m_exec) begin
      if (bus.ex_done) begin
        m_exec <= 1'b0; m_wait <= 1'b1;
      end
    end else if (bus.start) begin
      m_wait <= 1'b1;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    logic [3:0] op;
    logic take, e_fetch, e_pcw, e_exs, e_req, e_halt;
    logic [9:0] e_addr, e_maddr;
    logic [15:0] e_ir;
    if (cmp_en) begin
      op      = m_ir[15:12];
      take    = m_dec && (op == 4'hE || (op == 4'hD && bus.zero));
      e_pcw   = take;
      e_addr  = take ? m_ir[9:0] : 10'd0;
      e_fetch = (m_dec && op == 4'hD && !bus.zero) || (m_exec && bus.ex_done);
      e_exs   = m_dec && op != 4'hE && op != 4'hD && op != 4'hF;
      e_req   = m_wait;
      e_maddr = m_wait ? bus.PC : 10'd0;
      e_halt  = m_halt;
      e_ir    = m_ir;
      if (rst) begin
        e_pcw = 1'b0; e_addr = 10'd0; e_fetch = 1'b0; e_exs = 1'b0;
        e_req = 1'b0; e_maddr = 10'd0; e_halt = 1'b0; e_ir = 16'h0000;
      end
      chk("m_fetch", 32'(bus.fetch), 32'(e_fetch));
      chk("m_pc_write", 32'(bus.pc_write), 32'(e_pcw));
      chk("m_addr", 32'(bus.addr), 32'(e_addr));
      chk("m_ex_start", 32'(bus.ex_start), 32'(e_exs));
      chk("m_mem_req", 32'(bus.mem_req), 32'(e_req));
      chk("m_mem_addr", 32'(bus.mem_addr), 32'(e_maddr));
      chk("m_halted", 32'(bus.halted), 32'(e_halt));
      chk("m_ir", 32'(bus.ir), 32'(e_ir));
      chk("m_excl", 32'(bus.fetch & bus.pc_write), 32'd0);
    end
  end

  task automatic clear_inputs();
    bus.start = 1'b0; bus.PC = 10'd0; bus.pc_overflow = 1'b0; bus.mem_ack = 1'b0;
    bus.mem_data = 16'h0000; bus.zero = 1'b0; bus.ex_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ir", 32'(bus.ir), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_strobes", 32'({bus.fetch, bus.pc_write, bus.ex_start}), 32'h0);
    step();
    rst = 1'b0;
  endtask

  task automatic launch();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic load(input logic [15:0] data);
    bus.mem_ack = 1'b1;
    bus.mem_data = data;
    step();
    bus.mem_ack = 1'b0;
  endtask

  int reqcnt, fcnt;

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    cmp_en = 1'b1;
    do_reset();

    // Fetch with a 3-cycle memory latency, then an execute-class instruction.
    @(negedge clk);
    chk("idle_mem_req", 32'(bus.mem_req), 32'h0);
    launch();
    reqcnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus.PC = 10'd0; bus.mem_data = 16'h1234; bus.mem_ack = (k == 2);
      @(negedge clk);
      reqcnt += int'(bus.mem_req);
      chk("fetch_addr", 32'(bus.mem_addr), 32'h0);
      step();
    end
    bus.mem_ack = 1'b0;
    chk("req_cycles", 32'(reqcnt), 32'd3);
    @(negedge clk);
    chk("ir_load", 32'(bus.ir), 32'h1234);
    chk("ex_start_pulse", 32'(bus.ex_start), 32'h1);
    step();
    fcnt = 0;
    for (int e = 0; e < 4; e++) begin
      bus.ex_done = (e == 3);
      @(negedge clk);
      fcnt += int'(bus.fetch);
      chk("exec_ex_start_low", 32'(bus.ex_start), 32'h0);
      if (e == 3) chk("fetch_on_done", 32'(bus.fetch), 32'h1);
      step();
    end
    bus.ex_done = 1'b0;
    chk("fetch_count", 32'(fcnt), 32'd1);
    @(negedge clk);
    chk("refetch", 32'(bus.mem_req), 32'h1);

    // JMP
    load(16'hE032);
    @(negedge clk);
    chk("jmp_pcw", 32'(bus.pc_write), 32'h1);
    chk("jmp_addr", 32'(bus.addr), 32'd50);
    chk("jmp_fetch", 32'(bus.fetch), 32'h0);
    step();
    @(negedge clk);
    chk("jmp_pcw_once", 32'(bus.pc_write), 32'h0);

    // BZ taken, then not taken
    load(16'hD064);
    bus.zero = 1'b1;
    @(negedge clk);
    chk("bz1_pcw", 32'(bus.pc_write), 32'h1);
    chk("bz1_addr", 32'(bus.addr), 32'd100);
    step();
    bus.zero = 1'b0;
    load(16'hD064);
    @(negedge clk);
    chk("bz0_fetch", 32'(bus.fetch), 32'h1);
    chk("bz0_pcw", 32'(bus.pc_write), 32'h0);
    step();

    // HLT is sticky against start and mem_ack
    load(16'hF000);
    @(negedge clk);
    chk("hlt_strobes", 32'({bus.fetch, bus.pc_write, bus.ex_start}), 32'h0);
    step();
    bus.start = 1'b1; bus.mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_sticky", 32'(bus.halted), 32'h1);
      chk("halt_no_req", 32'(bus.mem_req), 32'h0);
      step();
    end

    // pc_overflow in FETCH overrides mem_ack
    do_reset();
    launch();
    bus.pc_overflow = 1'b1; bus.mem_ack = 1'b1; bus.mem_data = 16'h1234;
    step();
    bus.pc_overflow = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("ovf_halted", 32'(bus.halted), 32'h1);
    chk("ovf_ir", 32'(bus.ir), 32'h0);
    step();

    // Reset in the middle of EXEC
    do_reset();
    launch();
    load(16'h1234);
    step();
    bus.ex_done = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_fetch", 32'(bus.fetch), 32'h0);
    chk("rst_exec_ir", 32'(bus.ir), 32'h0);
    step();
    rst = 1'b0;
    bus.ex_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_fetch", 32'(bus.fetch), 32'h0);
      chk("post_rst_req", 32'(bus.mem_req), 32'h0);
      step();
    end

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [3:0] op;
      r = int'($urandom_range(0, 9));
      if (r < 3) op = 4'hE;
      else if (r < 6) op = 4'hD;
      else if (r == 6) op = 4'hF;
      else op = 4'($urandom_range(0, 12));
      rst             = ($urandom_range(0, 79) == 0);
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.mem_ack     = ($urandom_range(0, 2) == 0);
      bus.mem_data    = {op, 12'($urandom_range(0, 4095))};
      bus.zero        = 1'($urandom_range(0, 1));
      bus.ex_done     = ($urandom_range(0, 2) == 0);
      bus.pc_overflow = ($urandom_range(0, 29) == 0);
      bus.PC          = 10'($urandom_range(0, 1023));
      step();
    end
    rst = 1'b0;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
